// File: rtl/seg7_pkg.sv
// seg7_pkg: segment codes, BCD-to-segment decode and conversion state type
// Segment vectors are {a,b,c,d,e,f,g}, bit 6 = a, active-low.
package seg7_pkg;
   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_DONE} conv_state_t;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
      case (n)
         4'd0: return SEG_0;
         4'd1: return SEG_1;
         4'd2: return SEG_2;
         4'd3: return SEG_3;
         4'd4: return SEG_4;
         4'd5: return SEG_5;
         4'd6: return SEG_6;
         4'd7: return SEG_7;
         4'd8: return SEG_8;
         4'd9: return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter
// Ports: clk, rst (async high); value/load capture and start; busy while
// converting; ovf = last value exceeded 10^DIGITS-1; bcd result; valid pulses
// in DONE when the result is to be taken.
module bin2bcd_seq
   import seg7_pkg::*;
#(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BIN_W-1:0]      value,
   input  logic                  load,
   output logic                  busy,
   output logic                  ovf,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  valid
);
   localparam int CW = BIN_W > 1 ? $clog2(BIN_W) : 1;
   localparam logic [63:0] MAXV = 64'(10**DIGITS - 1);

   conv_state_t           r_state, w_next;
   logic [BIN_W-1:0]      r_sh;
   logic [4*DIGITS-1:0]   r_bcd, w_adj;
   logic [CW-1:0]         r_cnt;
   logic                  r_ovf_nx, r_ovf;

   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;

   // a load in any state restarts; DONE always returns to IDLE
   always_comb begin
      w_next = r_state;
      if (load)                                             w_next = ST_CONV;
      else if (r_state == ST_CONV && r_cnt == CW'(BIN_W-1)) w_next = ST_DONE;
      else if (r_state == ST_DONE)                          w_next = ST_IDLE;
   end

   always_comb begin
      w_adj = r_bcd;
      for (int i = 0; i < DIGITS; i++)
         if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_sh     <= '0;
         r_bcd    <= '0;
         r_cnt    <= '0;
         r_ovf_nx <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (load) begin
         r_sh     <= value;
         r_bcd    <= '0;
         r_cnt    <= '0;
         r_ovf_nx <= 64'(value) > MAXV;
      end else if (r_state == ST_CONV) begin
         {r_bcd, r_sh} <= {w_adj, r_sh} << 1;
         r_cnt         <= r_cnt + 1'b1;
      end else if (r_state == ST_DONE) begin
         r_ovf <= r_ovf_nx;
      end

   assign busy  = r_state != ST_IDLE;
   assign valid = r_state == ST_DONE && !load;
   assign ovf   = r_ovf;
   assign bcd   = r_bcd;
endmodule

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: multiplexed N-digit 7-segment driver with BCD conversion
// Ports: clk, rst (async high); value/load start a conversion; blank_lz
// blanks leading zeros; blink_en blinks the display; busy/ovf status;
// seg active-low segments (bit 6 = a); an active-low one-hot digit enables.
module seg7_scan_mux
   import seg7_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int BIN_W       = 14,
   parameter int CLK_DIV     = 50000,
   parameter int BLINK_TICKS = 250
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BIN_W-1:0]  value,
   input  logic              load,
   input  logic              blank_lz,
   input  logic              blink_en,
   output logic              busy,
   output logic              ovf,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an
);
   localparam int IW  = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam int DW  = $clog2(CLK_DIV);
   localparam int BKW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;

   logic [DW-1:0]         r_div;
   logic [IW-1:0]         r_idx;
   logic [BKW-1:0]        r_bcnt;
   logic                  r_phase;
   logic [4*DIGITS-1:0]   r_disp, w_bcd;
   logic [6:0]            r_seg, w_seg;
   logic [DIGITS-1:0]     r_an, w_an;
   logic                  w_tick, w_valid, w_lz, w_blast;
   logic [3:0]            w_nib;

   bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_conv (
      .clk   (clk),
      .rst   (rst),
      .value (value),
      .load  (load),
      .busy  (busy),
      .ovf   (ovf),
      .bcd   (w_bcd),
      .valid (w_valid)
   );

   assign w_tick  = r_div == DW'(CLK_DIV-1);
   assign w_blast = r_bcnt == BKW'(BLINK_TICKS-1);
   assign w_nib   = 4'(r_disp >> {r_idx, 2'b00});
   // blank when this digit and every more-significant digit is zero
   assign w_lz    = blank_lz && r_idx != '0 && (r_disp >> {r_idx, 2'b00}) == '0;
   assign w_seg   = ovf ? SEG_DASH : w_lz ? SEG_BLANK : bcd_to_seg(w_nib);
   assign w_an    = (blink_en && r_phase) ? '1 : ~(DIGITS'(1) << r_idx);

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_div   <= '0;
         r_idx   <= '0;
         r_bcnt  <= '0;
         r_phase <= 1'b0;
         r_disp  <= '0;
         r_seg   <= SEG_BLANK;
         r_an    <= '1;
      end else begin
         r_div <= w_tick ? '0 : r_div + 1'b1;
         if (w_tick) r_idx <= r_idx == IW'(DIGITS-1) ? '0 : r_idx + 1'b1;
         if (!blink_en) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
         end else if (w_tick) begin
            r_bcnt <= w_blast ? '0 : r_bcnt + 1'b1;
            if (w_blast) r_phase <= ~r_phase;
         end
         if (w_valid) r_disp <= w_bcd;
         r_seg <= w_seg;
         r_an  <= w_an;
      end

   assign seg = r_seg;
   assign an  = r_an;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: directed self-checking bench for seg7_scan_mux
module tb_seg7_scan_mux;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [13:0] value = '0;
   logic        load = 1'b0;
   logic        blank_lz = 1'b0;
   logic        blink_en = 1'b0;
   logic        busy, ovf;
   logic [6:0]  seg;
   logic [3:0]  an;
   int          n_chk = 0;
   int          n_err = 0;
   bit          seen_one;

   localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                          S3 = 7'b0000110, S4 = 7'b1001100, S7 = 7'b0001111,
                          S9 = 7'b0000100, SD = 7'b1111110, SB = 7'b1111111;

   seg7_scan_mux #(.DIGITS(4), .BIN_W(14), .CLK_DIV(4), .BLINK_TICKS(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .value    (value),
      .load     (load),
      .blank_lz (blank_lz),
      .blink_en (blink_en),
      .busy     (busy),
      .ovf      (ovf),
      .seg      (seg),
      .an       (an)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic show(input int k, input logic [6:0] exp, input string tag);
      logic [3:0] p;
      int t;
      p = ~(4'b0001 << k);
      t = 0;
      while (an !== p && t < 40) begin
         @(negedge clk);
         t++;
      end
      check($sformatf("%s_d%0d", tag, k), {an, 1'b0, seg}, {p, 1'b0, exp});
   endtask

   task automatic do_load(input logic [13:0] v);
      value = v;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      while (busy && t < 60) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_idle"}, busy, 0);
      @(negedge clk);
   endtask

   initial begin
      int cnt, dark, lit;
      repeat (3) @(negedge clk);
      check("rst_seg", seg, SB);
      check("rst_an", an, 4'hF);
      check("rst_busy", busy, 0);
      check("rst_ovf", ovf, 0);
      rst = 1'b0;
      @(negedge clk);
      check("first_digit", {an, 1'b0, seg}, {4'b1110, 1'b0, S0});
      for (int k = 1; k < 4; k++) show(k, S0, "init");

      do_load(14'd1234);
      cnt = 0;
      while (busy && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      check("busy_len_1234", cnt, 15);
      show(0, S4, "v1234");
      show(1, S3, "v1234");
      show(2, S2, "v1234");
      show(3, S1, "v1234");

      blank_lz = 1'b1;
      do_load(14'd7);
      wait_idle("v7");
      show(0, S7, "lz7");
      for (int k = 1; k < 4; k++) show(k, SB, "lz7");
      blank_lz = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 1; k < 4; k++) show(k, S0, "nolz7");

      do_load(14'd10000);
      wait_idle("v10000");
      check("ovf_set", ovf, 1);
      for (int k = 0; k < 4; k++) show(k, SD, "ovf");
      do_load(14'd9999);
      wait_idle("v9999");
      check("ovf_clr", ovf, 0);
      for (int k = 0; k < 4; k++) show(k, S9, "v9999");

      seen_one = 1'b0;
      do_load(14'd1234);
      repeat (2) @(negedge clk);
      do_load(14'd42);
      cnt = 0;
      while (busy && cnt < 40) begin
         if (seg == S1) seen_one = 1'b1;
         cnt++;
         @(negedge clk);
      end
      check("busy_len_restart", cnt, 15);
      repeat (20) begin
         if (seg == S1) seen_one = 1'b1;
         @(negedge clk);
      end
      check("no_stale_1234", seen_one, 0);
      show(0, S2, "v42");
      show(1, S4, "v42");
      show(2, S0, "v42");
      show(3, S0, "v42");

      blink_en = 1'b1;
      cnt = 0;
      while (an !== 4'hF && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      dark = 0;
      while (an === 4'hF && dark < 40) begin
         dark++;
         @(negedge clk);
      end
      lit = 0;
      while (an !== 4'hF && lit < 40) begin
         lit++;
         @(negedge clk);
      end
      check("blink_dark", dark, 8);
      check("blink_lit", lit, 8);
      blink_en = 1'b0;
      repeat (2) @(negedge clk);

      do_load(14'd9999);
      repeat (5) @(negedge clk);
      check("conv_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("arst_busy", busy, 0);
      check("arst_out", {an, 1'b0, seg}, {4'hF, 1'b0, SB});
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("post_rst_busy", busy, 0);
      for (int k = 0; k < 4; k++) show(k, S0, "post_rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
